// File: rtl/uart_prog_loader.sv
// uart_prog_loader: receives a length-prefixed program image over UART 8N1,
// packs it into 32-bit little-endian words and writes them into instruction
// ROM through the upg_* port. While a load runs the CPU is held off the ROM.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | after reset, CPU owns ROM, waiting for start
// LEN0  | waiting for word-count low byte
// LEN1  | waiting for word-count high byte, range-checked on arrival
// DATA  | collecting the four bytes of the current word
// WRITE | single-cycle ROM write of the assembled word
// DONE  | image complete, CPU owns ROM again, done flag held
// ERR   | load aborted (bad length, framing error or timeout)
module uart_prog_loader #(
  parameter int CLK_FREQ    = 100000000,
  parameter int BAUD        = 115200,
  parameter int TIMEOUT_CYC = 10000000,
  parameter int MAX_WORDS   = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx,
  output logic        upg_rst_o,
  output logic        upg_wen_o,
  output logic [13:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        busy,
  output logic        err
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int BW       = $clog2(BAUD_DIV + 1);
  localparam int TW       = $clog2(TIMEOUT_CYC + 1);

  localparam logic [BW-1:0] HALF_LD = BW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] FULL_LD = BW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] TO_LD   = TW'(TIMEOUT_CYC - 1);
  localparam logic [16:0]   MAX_N   = 17'(MAX_WORDS);

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t       rx_state, rx_state_nx;
  logic            rx_s1, rx_s2, rx_prev;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      rx_shift;
  logic            byte_valid, frame_err;
  logic            baud_tc, rx_fall;

  assign baud_tc = (baud_cnt == '0);
  assign rx_fall = rx_prev & ~rx_s2;

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Receiver state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_state <= RX_IDLE;
    else      rx_state <= rx_state_nx;
  end

  // Receiver next state: start-bit recheck at mid-bit filters glitches
  always_comb begin
    rx_state_nx = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_state_nx = RX_START;
      RX_START: if (baud_tc) rx_state_nx = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (baud_tc && bit_idx == 3'd7) rx_state_nx = RX_STOP;
      RX_STOP:  if (baud_tc) rx_state_nx = RX_IDLE;
      default:  rx_state_nx = RX_IDLE;
    endcase
  end

  // Receiver datapath: baud down-counter, LSB-first shifter, byte/frame pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt   <= '0;
      bit_idx    <= 3'd0;
      rx_shift   <= 8'd0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (rx_state == RX_IDLE) begin
        if (rx_fall) baud_cnt <= HALF_LD;
      end else if (baud_tc) begin
        baud_cnt <= FULL_LD;
      end else begin
        baud_cnt <= baud_cnt - 1'b1;
      end
      if (rx_state == RX_START) bit_idx <= 3'd0;
      if (rx_state == RX_DATA && baud_tc) begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        bit_idx  <= bit_idx + 3'd1;
      end
      if (rx_state == RX_STOP && baud_tc) begin
        byte_valid <= rx_s2;
        frame_err  <= ~rx_s2;
      end
    end
  end

  // ---------------- loader FSM ----------------
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR} state_t;

  state_t        state, state_nx;
  logic [15:0]   n_words;
  logic [15:0]   len_full;
  logic [1:0]    k;
  logic [TW-1:0] idle_cnt;
  logic          active, idle_tc, len_bad, last_word, can_start;

  assign active    = (state == LEN0) || (state == LEN1) || (state == DATA);
  assign idle_tc   = active && (idle_cnt == '0) && !byte_valid;
  assign len_full  = {rx_shift, n_words[7:0]};
  assign len_bad   = (len_full == 16'd0) || ({1'b0, len_full} > MAX_N);
  assign last_word = ({2'b00, upg_adr_o} == (n_words - 16'd1));
  assign can_start = start && (state == IDLE || state == DONE || state == ERR);

  // Loader state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Loader next state: start only honoured when not busy, aborts take priority
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nx = LEN0;
      LEN0: begin
        if (frame_err || idle_tc) state_nx = ERR;
        else if (byte_valid)      state_nx = LEN1;
      end
      LEN1: begin
        if (frame_err || idle_tc) state_nx = ERR;
        else if (byte_valid)      state_nx = len_bad ? ERR : DATA;
      end
      DATA: begin
        if (frame_err || idle_tc)         state_nx = ERR;
        else if (byte_valid && k == 2'd3) state_nx = WRITE;
      end
      WRITE:   state_nx = last_word ? DONE : DATA;
      default: state_nx = IDLE;
    endcase
  end

  // Loader datapath: length, word assembly, address and inter-byte timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_words   <= 16'd0;
      k         <= 2'd0;
      upg_adr_o <= 14'd0;
      upg_dat_o <= 32'd0;
      idle_cnt  <= '0;
    end else begin
      if (can_start || byte_valid) idle_cnt <= TO_LD;
      else if (active && idle_cnt != '0) idle_cnt <= idle_cnt - 1'b1;
      if (can_start) begin
        upg_adr_o <= 14'd0;
        k         <= 2'd0;
      end
      case (state)
        LEN0: if (byte_valid) n_words[7:0]  <= rx_shift;
        LEN1: if (byte_valid) n_words[15:8] <= rx_shift;
        DATA: begin
          if (byte_valid) begin
            upg_dat_o[{k, 3'b000} +: 8] <= rx_shift;
            k <= k + 2'd1;
          end
        end
        WRITE: begin
          k <= 2'd0;
          if (!last_word) upg_adr_o <= upg_adr_o + 14'd1;
        end
        default: ;
      endcase
    end
  end

  // Loader outputs decoded from state so async reset clears them immediately
  always_comb begin
    upg_wen_o  = 1'b0;
    busy       = 1'b0;
    upg_done_o = 1'b0;
    err        = 1'b0;
    case (state)
      LEN0, LEN1, DATA: busy = 1'b1;
      WRITE: begin
        busy      = 1'b1;
        upg_wen_o = 1'b1;
      end
      DONE:    upg_done_o = 1'b1;
      ERR:     err        = 1'b1;
      default: ;
    endcase
    upg_rst_o = ~busy;
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: directed and randomized image loads over a
// fast UART (16 clocks per bit), checked against a byte-stream model.
module tb_uart_prog_loader;

  localparam int CLK_FREQ    = 160;
  localparam int BAUD        = 10;
  localparam int BIT_CYC     = CLK_FREQ / BAUD;
  localparam int TIMEOUT_CYC = 1000;
  localparam int MAX_WORDS   = 16384;

  // status vector {upg_rst_o, busy, upg_done_o, err}
  localparam logic [3:0] ST_IDLE = 4'b1000;
  localparam logic [3:0] ST_BUSY = 4'b0100;
  localparam logic [3:0] ST_DONE = 4'b1010;
  localparam logic [3:0] ST_ERR  = 4'b1001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        rx = 1'b1;
  logic        upg_rst_o, upg_wen_o, upg_done_o, busy, err;
  logic [13:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic [3:0]  st;

  assign st = {upg_rst_o, busy, upg_done_o, err};

  uart_prog_loader #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rx(rx),
    .upg_rst_o(upg_rst_o), .upg_wen_o(upg_wen_o), .upg_adr_o(upg_adr_o),
    .upg_dat_o(upg_dat_o), .upg_done_o(upg_done_o), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0]  tx_q[$];   // {stop bit, data byte}
  logic [45:0] exp_q[$];  // {adr, dat}
  logic [45:0] got_q[$];
  logic [3:0]  exp_st;
  logic [13:0] exp_adr;
  logic [31:0] exp_dat;
  int          need;
  logic        prev_wen = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ROM write monitor: record every write, each pulse must be one cycle wide
  always @(negedge clk) begin
    if (upg_wen_o) begin
      check("wen_pulse_width", {63'd0, prev_wen}, 64'd0);
      got_q.push_back({upg_adr_o, upg_dat_o});
    end
    prev_wen <= upg_wen_o;
  end

  // Reference: walk the byte stream as the loader protocol describes it
  task automatic model();
    int n, j;
    logic [31:0] w;
    exp_q.delete();
    exp_st = ST_BUSY;
    need = 0;
    n = 0;
    w = 32'd0;
    for (int i = 0; i < tx_q.size(); i++) begin
      if (exp_st != ST_BUSY) break;
      if (tx_q[i][8] == 1'b0) begin
        exp_st = ST_ERR;
        break;
      end
      if (i == 0) n = int'(tx_q[i][7:0]);
      else if (i == 1) begin
        n = n + 256 * int'(tx_q[i][7:0]);
        if (n == 0 || n > MAX_WORDS) exp_st = ST_ERR;
      end else begin
        j = i - 2;
        w[8*(j%4) +: 8] = tx_q[i][7:0];
        if (j % 4 == 3) begin
          exp_adr = 14'(j / 4);
          exp_dat = w;
          exp_q.push_back({exp_adr, exp_dat});
          if (j / 4 == n - 1) begin
            exp_st = ST_DONE;
            need = i + 1;
          end
        end
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [8:0] b);
    rx = 1'b0;
    idle_cycles(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle_cycles(BIT_CYC);
    end
    rx = b[8];
    idle_cycles(BIT_CYC);
    rx = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic glitch();
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    idle_cycles(30);
  endtask

  task automatic compare_result();
    check("n_writes", 64'(got_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i])
      if (i < got_q.size()) check("write_adr_dat", 64'(got_q[i]), 64'(exp_q[i]));
    check("status", 64'(st), 64'(exp_st));
    if (exp_st == ST_DONE) begin
      check("done_adr", 64'(upg_adr_o), 64'(exp_adr));
      check("done_dat", 64'(upg_dat_o), 64'(exp_dat));
    end
  endtask

  // Start a load, stream tx_q, optionally inject rx glitches and start pulses
  // while the model says the load is still in progress
  task automatic run_load(input bit noise);
    model();
    got_q.delete();
    pulse_start();
    check("start_busy", 64'(st), 64'(ST_BUSY));
    if (noise) glitch();
    for (int i = 0; i < tx_q.size(); i++) begin
      send_byte(tx_q[i]);
      idle_cycles($urandom_range(2, 20));
      if (noise && i + 1 < need) begin
        if ($urandom_range(0, 1) == 1) glitch();
        if ($urandom_range(0, 1) == 1) begin
          pulse_start();
          idle_cycles(2);
        end
      end
    end
    idle_cycles(40);
    compare_result();
  endtask

  task automatic check_reset_values(input string tag);
    check(tag, {st, upg_wen_o, upg_adr_o, upg_dat_o}, {ST_IDLE, 1'b0, 14'd0, 32'd0});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int nw;
    #23;
    check_reset_values("reset_values");
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(5);
    check_reset_values("after_reset_release");

    glitch();
    idle_cycles(20);
    check("glitch_idle", 64'(st), 64'(ST_IDLE));

    // two-word image
    tx_q = '{9'h102, 9'h100, 9'h113, 9'h100, 9'h100, 9'h100,
             9'h193, 9'h100, 9'h110, 9'h100};
    run_load(1'b0);

    // bad lengths
    tx_q = '{9'h100, 9'h100};
    run_load(1'b0);
    tx_q = '{9'h101, 9'h140};
    run_load(1'b0);

    // framing error on first data byte
    tx_q = '{9'h101, 9'h100, 9'h013};
    run_load(1'b0);

    // timeout after two data bytes: byte_valid lies inside the final stop bit
    tx_q = '{9'h101, 9'h100, 9'h1AA, 9'h155};
    model();
    got_q.delete();
    pulse_start();
    for (int i = 0; i < tx_q.size(); i++) begin
      send_byte(tx_q[i]);
      if (i < tx_q.size() - 1) idle_cycles(5);
    end
    cyc = 0;
    while (err !== 1'b1 && cyc < TIMEOUT_CYC + 200) begin
      @(negedge clk);
      cyc++;
    end
    check("timeout_window", 64'(cyc >= TIMEOUT_CYC - BIT_CYC && cyc <= TIMEOUT_CYC), 64'd1);
    check("timeout_status", 64'(st), 64'(ST_ERR));
    check("timeout_no_write", 64'(got_q.size()), 64'd0);

    // maximum length is accepted, then async reset mid-transfer
    tx_q = '{9'h100, 9'h140};
    run_load(1'b0);
    rst = 1'b0;
    #1;
    check_reset_values("reset_max_len");
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(5);

    // reset after two data bytes, then a clean single-word load
    tx_q = '{9'h101, 9'h100, 9'h1AA, 9'h1BB};
    got_q.delete();
    pulse_start();
    foreach (tx_q[i]) begin
      send_byte(tx_q[i]);
      idle_cycles(4);
    end
    rst = 1'b0;
    #1;
    check_reset_values("reset_mid_data");
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(5);
    tx_q = '{9'h101, 9'h100, 9'h1EF, 9'h1BE, 9'h1AD, 9'h1DE};
    run_load(1'b0);

    // randomized images with noise and trailing extra bytes
    for (int r = 0; r < 5; r++) begin
      nw = $urandom_range(1, 3);
      tx_q.delete();
      tx_q.push_back({1'b1, 8'(nw)});
      tx_q.push_back(9'h100);
      for (int b = 0; b < 4 * nw + int'($urandom_range(0, 2)); b++)
        tx_q.push_back({1'b1, 8'($urandom_range(0, 255))});
      run_load(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Upstream feeder of the instruction-fetch stage's ROM programming port.
- Receives a program image over a UART 8N1 line and assembles it into 32-bit little-endian words.
- Writes each word into instruction ROM via the upg_* write interface, then hands ROM ownership back to the CPU.
- Also drives the CPU-hold and done signals the fetch stage uses to select CPU vs. loader access to the ROM.

Parameters:
- CLK_FREQ, 100000000, clk frequency in Hz.
- BAUD, 115200, UART bit rate; BAUD_DIV = CLK_FREQ/BAUD (integer division).
- TIMEOUT_CYC, 10000000, max idle clk cycles between bytes inside a transfer before abort.
- MAX_WORDS, 16384, ROM depth in words (14-bit address).

Ports:
- clk  in  1  loader clock; also drives the ROM upg clock externally.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse (already debounced/edge-detected); begins a load.
- rx  in  1  UART serial input, idle high, asynchronous to clk.
- upg_rst_o  out  1  1 = CPU owns ROM; 0 = loader owns ROM.
- upg_wen_o  out  1  ROM write enable, one-cycle pulse per word.
- upg_adr_o  out  14  ROM word address.
- upg_dat_o  out  32  ROM write data.
- upg_done_o  out  1  1 after a complete successful load; held until next start or reset.
- busy  out  1  load in progress.
- err  out  1  last load aborted (length, framing or timeout error).

Behaviour:
- Reset values: upg_rst_o=1, upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, upg_done_o=0, busy=0, err=0; FSM=IDLE; receiver idle.
- Receiver:
  - rx passes through a 2-flop synchronizer.
  - A start bit is detected on a synchronized 1->0 transition while the receiver is idle.
  - Start bit is re-checked at BAUD_DIV/2; if it reads high, it is a glitch and the receiver returns to idle.
  - 8 data bits are sampled at successive BAUD_DIV intervals, LSB first.
  - Stop bit is sampled one BAUD_DIV later: stop=1 raises byte_valid for 1 cycle; stop=0 raises frame_err for 1 cycle.
- FSM states: IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR.
  - IDLE/DONE/ERR + start: go to LEN0; upg_rst_o=0, busy=1, upg_done_o=0, err=0, upg_adr_o=0, byte index=0.
  - start is ignored while busy=1.
  - LEN0: byte_valid -> N[7:0]=byte; go to LEN1.
  - LEN1: byte_valid -> N[15:8]=byte.
    - N==0 or N>MAX_WORDS: go to ERR.
    - Otherwise: go to DATA.
  - DATA: byte_valid -> upg_dat_o[8k+7:8k]=byte (k = byte index 0..3), k++.
    - On k==3: go to WRITE.
  - WRITE (exactly 1 cycle): upg_wen_o=1 with the current upg_adr_o and the fully assembled upg_dat_o.
    - If upg_adr_o==N-1: go to DONE.
    - Otherwise: upg_adr_o+1 on exit, k=0, go to DATA.
  - DONE: upg_wen_o=0, upg_done_o=1, upg_rst_o=1, busy=0; upg_adr_o holds the last address.
  - ERR: upg_rst_o=1, err=1, busy=0, upg_done_o=0, upg_wen_o=0.
- Write latency: upg_wen_o asserts exactly 1 clk after the byte_valid of the 4th byte of a word.
- Address arithmetic: 14-bit, never wraps; the N bound guarantees the last address is at most MAX_WORDS-1.
- frame_err in LEN0/LEN1/DATA: go to ERR.
- Timeout: an idle counter resets on every byte_valid and on entry to LEN0. If it reaches TIMEOUT_CYC in LEN0/LEN1/DATA, go to ERR. The counter is inactive in other states.
- Bytes received in IDLE/DONE/ERR are discarded and do not change outputs.
- Extra bytes after DONE are ignored.
- Reset mid-load: all outputs return to reset values immediately (async); the partial ROM contents are left as-is.
- Simultaneous start and byte_valid in DONE/ERR: start wins; the byte is discarded.

Test Plan:
- Reset, then start, then bytes 02 00 | 13 00 00 00 | 93 00 10 00 -> two upg_wen_o pulses: (adr 0, dat 0x00000013), (adr 1, dat 0x00100093); then upg_done_o=1, upg_rst_o=1, busy=0, err=0.
- Length bytes 00 00, and separately 01 40 (N=16385) -> ERR: err=1, upg_rst_o=1, no wen pulses.
- Valid header N=1, then a byte with stop bit=0 -> ERR, err=1, no write.
- N=1, then 2 data bytes, then silence for TIMEOUT_CYC (bench TIMEOUT_CYC=1000) -> ERR at cycle 1000 after the last byte_valid.
- Assert rst low mid-DATA (after 2 of 4 bytes) -> all outputs at reset values; a following full load of N=1 (0xDEADBEEF sent as EF BE AD DE) writes adr 0 with dat 0xDEADBEEF.
- 1-cycle low glitch on rx in IDLE, plus start pulses while busy -> no byte_valid, FSM unchanged, no restart.
